// File: rtl/program_loader.sv
// program_loader: writer side of the instruction-memory interface.
//   Accepts a program as a valid/ready byte stream:
//     COUNT (N), then N words sent high byte first, then CHECK (XOR of the 2N word bytes).
//   Writes word k to instruction memory at address k, for k = 0..N-1.
//   After a good checksum it asserts cpu_run, which releases the core from hold.
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   start                  one-cycle pulse that opens a load session (from IDLE/DONE/ERR)
//   in_valid/in_data       byte source; in_ready is the loader's accept strobe
//   imem_we/addr/wdata     registered write port; we is high one cycle per word
//   cpu_run, done, error   session status, decoded from the state register
// ADDR_W is expected to be 8 or less, because N is a single byte.
module program_loader #(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [15:0]       imem_wdata,
    output logic              cpu_run,
    output logic              done,
    output logic              error
);
    typedef enum logic [2:0] {
        S_IDLE, S_COUNT, S_HI, S_LO, S_CHECK, S_DONE, S_ERR
    } state_t;

    localparam logic [8:0] DEPTH = 9'(1 << ADDR_W);

    state_t            state, next_state;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        count;
    logic [7:0]        chk;
    logic [7:0]        hi;
    logic              xfer;
    logic              count_bad;
    logic              last_word;

    // Status outputs are Moore decodes of the state register. Reset therefore
    // clears them immediately, and no path exists from in_valid to in_ready.
    assign in_ready  = (state == S_COUNT) || (state == S_HI) ||
                       (state == S_LO)    || (state == S_CHECK);
    assign done      = (state == S_DONE);
    assign cpu_run   = (state == S_DONE);
    assign error     = (state == S_ERR);

    assign xfer      = in_valid && in_ready;
    // The count check is done at 9 bits, so N == depth is accepted.
    assign count_bad = (in_data == 8'd0) || ({1'b0, in_data} > DEPTH);
    assign last_word = (8'(addr) == count - 8'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (start) next_state = S_COUNT;
            S_COUNT: if (xfer)  next_state = count_bad ? S_ERR : S_HI;
            S_HI:    if (xfer)  next_state = S_LO;
            S_LO:    if (xfer)  next_state = last_word ? S_CHECK : S_HI;
            S_CHECK: if (xfer)  next_state = (in_data == chk) ? S_DONE : S_ERR;
            S_DONE:  if (start) next_state = S_COUNT;
            S_ERR:   if (start) next_state = S_COUNT;
            default:            next_state = S_IDLE;
        endcase
    end

    // Datapath. The write is registered, so it lands in the cycle after the
    // low-byte handshake. That cycle overlaps the next HI or the CHECK byte,
    // so a continuous stream never stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr       <= '0;
            count      <= '0;
            chk        <= '0;
            hi         <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
        end else begin
            imem_we <= 1'b0;
            if (xfer) begin
                case (state)
                    S_COUNT: if (!count_bad) begin
                        count <= in_data;
                        addr  <= '0;
                        chk   <= '0;
                    end
                    S_HI: begin
                        hi  <= in_data;
                        chk <= chk ^ in_data;
                    end
                    S_LO: begin
                        chk        <= chk ^ in_data;
                        imem_we    <= 1'b1;
                        imem_addr  <= addr;
                        imem_wdata <= {hi, in_data};
                        // addr stops at N-1 and never wraps.
                        if (!last_word) addr <= addr + 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule
